// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: NOP encoding, writeback selects, forwarding selects
// and the control-field layouts of the IF/ID and ID/EX registers.
package pipe_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

   localparam logic [1:0] WB_ALU  = 2'b00;
   localparam logic [1:0] WB_LOAD = 2'b01;

   // Forward selects, E-stage operands and D-stage (branch compare) operands
   localparam logic [1:0] FWD_NONE = 2'b00;
   localparam logic [1:0] FWD_M2E  = 2'b01;
   localparam logic [1:0] FWD_W2E  = 2'b10;
   localparam logic [1:0] FWD_E2D  = 2'b01;
   localparam logic [1:0] FWD_M2D  = 2'b10;
   localparam logic [1:0] FWD_W2D  = 2'b11;

   typedef struct packed {
      logic [31:0] instr;
      logic        valid;
   } if_id_ctrl_t;

   typedef struct packed {
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [4:0] rd;
      logic [1:0] wb_ctrl;
      logic       we_reg;
      logic       valid;
   } id_ex_ctrl_t;

   localparam if_id_ctrl_t IF_ID_BUBBLE = '{instr: NOP_INSTR, valid: 1'b0};
   localparam id_ex_ctrl_t ID_EX_BUBBLE = '0;

endpackage

// File: rtl/pipe_reg.sv
// Generic pipeline register with synchronous reset, flush and enable.
// Priority: rst > flush > en.
module pipe_reg #(
   parameter int               WIDTH     = 32,
   parameter logic [WIDTH-1:0] RST_VAL   = '0,
   parameter logic [WIDTH-1:0] FLUSH_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             flush,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   // NOTE: non-blocking assignments keep every stage sampling the previous cycle's values.
   always_ff @(posedge clk) begin
      if (rst)
         q <= RST_VAL;
      else if (flush)
         q <= FLUSH_VAL;
      else if (en)
         q <= d;
   end

endmodule

// File: rtl/pipe_front_regs.sv
// PC, IF/ID and ID/EX registers of the 5-stage RV32I pipeline with stall/flush handling.
// Optional macro PIPE_PERF_CNT_EN adds saturating stall/flush performance counters.
module pipe_front_regs #(
   parameter int               XLEN      = 32,
   parameter logic [XLEN-1:0]  RESET_PC  = '0,
   parameter logic [31:0]      NOP_INSTR = pipe_pkg::NOP_INSTR
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall_F,
   input  logic            stall_D,
   input  logic            flush_D,
   input  logic            flush_E,
   input  logic            PC_src_D,
   input  logic [XLEN-1:0] PC_target_D,
   input  logic [31:0]     instr_F,
   input  logic [4:0]      rs1_D,
   input  logic [4:0]      rs2_D,
   input  logic [4:0]      rd_D,
   input  logic [1:0]      wb_ctrl_D,
   input  logic            we_reg_D,
   input  logic [XLEN-1:0] rd1_D,
   input  logic [XLEN-1:0] rd2_D,
   input  logic [XLEN-1:0] imm_D,
   output logic [XLEN-1:0] PC_F,
   output logic [XLEN-1:0] PC_D,
   output logic [31:0]     instr_D,
   output logic            valid_D,
   output logic [XLEN-1:0] PC_E,
   output logic [4:0]      rs1_E,
   output logic [4:0]      rs2_E,
   output logic [4:0]      rd_E,
   output logic [1:0]      wb_ctrl_E,
   output logic            we_reg_E,
   output logic [XLEN-1:0] rd1_E,
   output logic [XLEN-1:0] rd2_E,
   output logic [XLEN-1:0] imm_E,
   output logic            valid_E,
   output logic [31:0]     stall_cnt,
   output logic [31:0]     flushD_cnt,
   output logic [31:0]     flushE_cnt
);

   import pipe_pkg::*;

   localparam int IFID_W = XLEN + $bits(if_id_ctrl_t);
   localparam int IDEX_W = 4 * XLEN + $bits(id_ex_ctrl_t);

   localparam if_id_ctrl_t          IFID_CTRL_BUB = '{instr: NOP_INSTR, valid: 1'b0};
   localparam logic [IFID_W-1:0]    IFID_BUBBLE   = {{XLEN{1'b0}}, IFID_CTRL_BUB};

   // ---------------- PC ----------------
   logic [XLEN-1:0] pc_next;

   always_comb begin
      pc_next = PC_F + XLEN'(4);
      if (PC_src_D)
         pc_next = PC_target_D;
   end

   pipe_reg #(.WIDTH(XLEN), .RST_VAL(RESET_PC), .FLUSH_VAL(RESET_PC)) u_pc_reg (
      .clk   (clk),
      .rst   (rst),
      .en    (!stall_F),
      .flush (1'b0),
      .d     (pc_next),
      .q     (PC_F)
   );

   // ---------------- IF/ID ----------------
   if_id_ctrl_t       if_id_ctrl_d, if_id_ctrl_q;
   logic [IFID_W-1:0] if_id_q;

   assign if_id_ctrl_d = '{instr: instr_F, valid: 1'b1};

   pipe_reg #(.WIDTH(IFID_W), .RST_VAL(IFID_BUBBLE), .FLUSH_VAL(IFID_BUBBLE)) u_if_id_reg (
      .clk   (clk),
      .rst   (rst),
      .en    (!stall_D),
      .flush (flush_D),
      .d     ({PC_F, if_id_ctrl_d}),
      .q     (if_id_q)
   );

   assign {PC_D, if_id_ctrl_q} = if_id_q;
   assign instr_D = if_id_ctrl_q.instr;
   assign valid_D = if_id_ctrl_q.valid;

   // ---------------- ID/EX ----------------
   // A bubble clears rd/we_reg so it can never match a forwarding compare.
   id_ex_ctrl_t       id_ex_ctrl_d, id_ex_ctrl_q;
   logic [IDEX_W-1:0] id_ex_q;

   assign id_ex_ctrl_d = '{rs1: rs1_D, rs2: rs2_D, rd: rd_D, wb_ctrl: wb_ctrl_D,
                           we_reg: we_reg_D, valid: valid_D};

   pipe_reg #(.WIDTH(IDEX_W), .RST_VAL('0), .FLUSH_VAL('0)) u_id_ex_reg (
      .clk   (clk),
      .rst   (rst),
      .en    (1'b1),
      .flush (flush_E),
      .d     ({PC_D, rd1_D, rd2_D, imm_D, id_ex_ctrl_d}),
      .q     (id_ex_q)
   );

   assign {PC_E, rd1_E, rd2_E, imm_E, id_ex_ctrl_q} = id_ex_q;
   assign rs1_E     = id_ex_ctrl_q.rs1;
   assign rs2_E     = id_ex_ctrl_q.rs2;
   assign rd_E      = id_ex_ctrl_q.rd;
   assign wb_ctrl_E = id_ex_ctrl_q.wb_ctrl;
   assign we_reg_E  = id_ex_ctrl_q.we_reg;
   assign valid_E   = id_ex_ctrl_q.valid;

   // The hazard unit gates flush_D with the load stall; both together is a hazard-unit bug.
   assert property (@(posedge clk) disable iff (rst) !(flush_D && stall_D));

   // ---------------- performance counters ----------------
`ifdef PIPE_PERF_CNT_EN
   logic [31:0] stall_cnt_r, flushD_cnt_r, flushE_cnt_r;

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_r  <= '0;
         flushD_cnt_r <= '0;
         flushE_cnt_r <= '0;
      end else begin
         if (stall_F && stall_cnt_r != '1)
            stall_cnt_r <= stall_cnt_r + 32'd1;
         if (flush_D && flushD_cnt_r != '1)
            flushD_cnt_r <= flushD_cnt_r + 32'd1;
         if (flush_E && flushE_cnt_r != '1)
            flushE_cnt_r <= flushE_cnt_r + 32'd1;
      end
   end

   assign stall_cnt  = stall_cnt_r;
   assign flushD_cnt = flushD_cnt_r;
   assign flushE_cnt = flushE_cnt_r;
`else
   assign stall_cnt  = '0;
   assign flushD_cnt = '0;
   assign flushE_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_front_regs.sv
// Directed self-checking bench for pipe_front_regs; counter checks follow PIPE_PERF_CNT_EN.
module tb_pipe_front_regs;

   localparam logic [31:0] NOP    = 32'h0000_0013;
   localparam logic [31:0] ADDI   = 32'h0010_0093;
   localparam logic [31:0] ADD_DEP = 32'h0012_8333;  // add x6,x5,x1

   logic        clk = 1'b0;
   logic        rst, stall_F, stall_D, flush_D, flush_E, PC_src_D;
   logic [31:0] PC_target_D, instr_F;
   logic [4:0]  rs1_D, rs2_D, rd_D;
   logic [1:0]  wb_ctrl_D;
   logic        we_reg_D;
   logic [31:0] rd1_D, rd2_D, imm_D;
   logic [31:0] PC_F, PC_D, instr_D, PC_E;
   logic        valid_D, valid_E, we_reg_E;
   logic [4:0]  rs1_E, rs2_E, rd_E;
   logic [1:0]  wb_ctrl_E;
   logic [31:0] rd1_E, rd2_E, imm_E;
   logic [31:0] stall_cnt, flushD_cnt, flushE_cnt;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   pipe_front_regs dut (
      .clk(clk), .rst(rst), .stall_F(stall_F), .stall_D(stall_D),
      .flush_D(flush_D), .flush_E(flush_E), .PC_src_D(PC_src_D),
      .PC_target_D(PC_target_D), .instr_F(instr_F),
      .rs1_D(rs1_D), .rs2_D(rs2_D), .rd_D(rd_D), .wb_ctrl_D(wb_ctrl_D),
      .we_reg_D(we_reg_D), .rd1_D(rd1_D), .rd2_D(rd2_D), .imm_D(imm_D),
      .PC_F(PC_F), .PC_D(PC_D), .instr_D(instr_D), .valid_D(valid_D),
      .PC_E(PC_E), .rs1_E(rs1_E), .rs2_E(rs2_E), .rd_E(rd_E),
      .wb_ctrl_E(wb_ctrl_E), .we_reg_E(we_reg_E), .rd1_E(rd1_E),
      .rd2_E(rd2_E), .imm_E(imm_E), .valid_E(valid_E),
      .stall_cnt(stall_cnt), .flushD_cnt(flushD_cnt), .flushE_cnt(flushE_cnt)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_ctrl();
      stall_F = 0; stall_D = 0; flush_D = 0; flush_E = 0; PC_src_D = 0;
   endtask

   task automatic test_reset();
      rst = 1; idle_ctrl();
      PC_target_D = 32'h0; instr_F = ADDI;
      rs1_D = 5'd3; rs2_D = 5'd4; rd_D = 5'd7; wb_ctrl_D = 2'b01; we_reg_D = 1;
      rd1_D = 32'h11; rd2_D = 32'h22; imm_D = 32'h33;
      step(); step();
      total++; if (PC_F !== 32'h0) $display("FAIL reset_pc_f got %h exp %h", PC_F, 32'h0); else passed++;
      total++; if (instr_D !== NOP) $display("FAIL reset_instr_d got %h exp %h", instr_D, NOP); else passed++;
      total++; if (valid_D !== 1'b0 || valid_E !== 1'b0) $display("FAIL reset_valid got %b%b exp 00", valid_D, valid_E); else passed++;
      total++; if (rd_E !== 5'd0 || we_reg_E !== 1'b0 || wb_ctrl_E !== 2'b00) $display("FAIL reset_ex_ctrl got rd=%0d we=%b wb=%b exp 0 0 00", rd_E, we_reg_E, wb_ctrl_E); else passed++;
   endtask

   task automatic test_free_run();
      rst = 0;
      step();
      total++; if (PC_F !== 32'd4) $display("FAIL free_pc1 got %h exp %h", PC_F, 32'd4); else passed++;
      total++; if (valid_D !== 1'b1 || instr_D !== ADDI || PC_D !== 32'd0) $display("FAIL free_d1 got v=%b i=%h pc=%h exp 1 %h 0", valid_D, instr_D, PC_D, ADDI); else passed++;
      total++; if (valid_E !== 1'b0) $display("FAIL free_e1 got %b exp 0", valid_E); else passed++;
      step();
      total++; if (PC_F !== 32'd8 || PC_D !== 32'd4) $display("FAIL free_pc2 got F=%h D=%h exp 8 4", PC_F, PC_D); else passed++;
      total++; if (valid_E !== 1'b1 || PC_E !== 32'd0 || rd_E !== 5'd7) $display("FAIL free_e2 got v=%b pc=%h rd=%0d exp 1 0 7", valid_E, PC_E, rd_E); else passed++;
      step();
      total++; if (PC_F !== 32'd12) $display("FAIL free_pc3 got %h exp %h", PC_F, 32'd12); else passed++;
   endtask

   task automatic test_load_use();
      // lw x5 enters E while add x6,x5,x1 is fetched into D
      instr_F = ADD_DEP;
      rs1_D = 5'd2; rs2_D = 5'd0; rd_D = 5'd5; wb_ctrl_D = 2'b01; we_reg_D = 1;
      step();
      total++; if (rd_E !== 5'd5 || wb_ctrl_E !== 2'b01 || we_reg_E !== 1'b1) $display("FAIL lu_lw_in_e got rd=%0d wb=%b we=%b exp 5 01 1", rd_E, wb_ctrl_E, we_reg_E); else passed++;
      total++; if (instr_D !== ADD_DEP || PC_F !== 32'd16) $display("FAIL lu_add_in_d got i=%h pc=%h exp %h 10", instr_D, PC_F, ADD_DEP); else passed++;
      instr_F = 32'hDEAD_BEEF;
      rs1_D = 5'd5; rs2_D = 5'd1; rd_D = 5'd6; wb_ctrl_D = 2'b00; we_reg_D = 1;
      rd1_D = 32'hAAAA_0001; rd2_D = 32'hBBBB_0002; imm_D = 32'h0;
      stall_F = 1; stall_D = 1; flush_E = 1;
      step();
      total++; if (PC_F !== 32'd16 || instr_D !== ADD_DEP || PC_D !== 32'd12) $display("FAIL lu_hold got F=%h i=%h D=%h exp 10 %h c", PC_F, instr_D, PC_D, ADD_DEP); else passed++;
      total++; if (rd_E !== 5'd0 || we_reg_E !== 1'b0 || valid_E !== 1'b0 || rd1_E !== 32'h0) $display("FAIL lu_bubble got rd=%0d we=%b v=%b rd1=%h exp 0 0 0 0", rd_E, we_reg_E, valid_E, rd1_E); else passed++;
      idle_ctrl();
      step();
      total++; if (rs1_E !== 5'd5 || rd_E !== 5'd6 || valid_E !== 1'b1 || PC_E !== 32'd12) $display("FAIL lu_advance got rs1=%0d rd=%0d v=%b pc=%h exp 5 6 1 c", rs1_E, rd_E, valid_E, PC_E); else passed++;
      total++; if (rd1_E !== 32'hAAAA_0001 || rd2_E !== 32'hBBBB_0002) $display("FAIL lu_operands got %h %h exp aaaa0001 bbbb0002", rd1_E, rd2_E); else passed++;
      total++; if (PC_F !== 32'd20) $display("FAIL lu_pc_resume got %h exp %h", PC_F, 32'd20); else passed++;
   endtask

   task automatic test_branch();
      PC_src_D = 1; flush_D = 1; PC_target_D = 32'h0000_0100;
      step();
      total++; if (PC_F !== 32'h100) $display("FAIL br_pc got %h exp %h", PC_F, 32'h100); else passed++;
      total++; if (instr_D !== NOP || valid_D !== 1'b0 || PC_D !== 32'h0) $display("FAIL br_squash got i=%h v=%b pc=%h exp %h 0 0", instr_D, valid_D, PC_D, NOP); else passed++;
      idle_ctrl();
      step();
      total++; if (valid_E !== 1'b0 || PC_F !== 32'h104) $display("FAIL br_bubble_e got v=%b pc=%h exp 0 104", valid_E, PC_F); else passed++;
   endtask

   task automatic test_stall_vs_redirect();
      stall_F = 1; PC_src_D = 1; PC_target_D = 32'h0000_0200;
      step();
      total++; if (PC_F !== 32'h104) $display("FAIL sr_hold got %h exp %h", PC_F, 32'h104); else passed++;
      stall_F = 0;
      step();
      total++; if (PC_F !== 32'h200) $display("FAIL sr_redirect got %h exp %h", PC_F, 32'h200); else passed++;
      idle_ctrl();
      step();
      total++; if (PC_F !== 32'h204) $display("FAIL sr_after got %h exp %h", PC_F, 32'h204); else passed++;
   endtask

   task automatic test_reset_priority();
      rst = 1; stall_F = 1; stall_D = 1; flush_E = 1; PC_src_D = 1; PC_target_D = 32'h0000_0300;
      rs1_D = 5'd9; rd_D = 5'd9; we_reg_D = 1; imm_D = 32'h1234;
      step();
      total++; if (PC_F !== 32'h0 || PC_D !== 32'h0 || PC_E !== 32'h0) $display("FAIL rp_pcs got F=%h D=%h E=%h exp 0 0 0", PC_F, PC_D, PC_E); else passed++;
      total++; if (instr_D !== NOP || valid_D !== 1'b0 || valid_E !== 1'b0) $display("FAIL rp_d got i=%h vD=%b vE=%b exp %h 0 0", instr_D, valid_D, valid_E, NOP); else passed++;
      total++; if (rd_E !== 5'd0 || we_reg_E !== 1'b0 || imm_E !== 32'h0 || rs1_E !== 5'd0) $display("FAIL rp_e got rd=%0d we=%b imm=%h rs1=%0d exp 0 0 0 0", rd_E, we_reg_E, imm_E, rs1_E); else passed++;
      total++; if (stall_cnt !== 32'h0 || flushD_cnt !== 32'h0 || flushE_cnt !== 32'h0) $display("FAIL rp_cnt got %h %h %h exp 0 0 0", stall_cnt, flushD_cnt, flushE_cnt); else passed++;
      rst = 0; idle_ctrl();
   endtask

   task automatic test_perf_counters();
      stall_F = 1; flush_D = 1;
      step(); step(); step();
`ifdef PIPE_PERF_CNT_EN
      total++; if (stall_cnt !== 32'd3 || flushD_cnt !== 32'd3 || flushE_cnt !== 32'd0) $display("FAIL cnt_count got %0d %0d %0d exp 3 3 0", stall_cnt, flushD_cnt, flushE_cnt); else passed++;
      flush_D = 0;
      force dut.stall_cnt_r = 32'hFFFF_FFFE;
      #1;
      release dut.stall_cnt_r;
      step();
      total++; if (stall_cnt !== 32'hFFFF_FFFF) $display("FAIL cnt_reach_max got %h exp ffffffff", stall_cnt); else passed++;
      step();
      total++; if (stall_cnt !== 32'hFFFF_FFFF) $display("FAIL cnt_saturate got %h exp ffffffff", stall_cnt); else passed++;
      total++; if (flushD_cnt !== 32'd3) $display("FAIL cnt_flushd_hold got %0d exp 3", flushD_cnt); else passed++;
`else
      flush_E = 1;
      step();
      total++; if (stall_cnt !== 32'h0 || flushD_cnt !== 32'h0 || flushE_cnt !== 32'h0) $display("FAIL cnt_disabled got %h %h %h exp 0 0 0", stall_cnt, flushD_cnt, flushE_cnt); else passed++;
`endif
      idle_ctrl();
   endtask

   initial begin
      test_reset();
      test_free_run();
      test_load_use();
      test_branch();
      test_stall_vs_redirect();
      test_reset_priority();
      test_perf_counters();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
